// File: rtl/mmio_demux.sv
// Routes one load/store request to the address-selected MMIO slave and returns a single response.
// Define MMIO_TIMEOUT_EN to add a slave timeout that turns stalled transactions into error responses.
module mmio_demux #(
   parameter int unsigned NUM_DEV     = 4,
   parameter int unsigned SEL_MSB     = 31,
   parameter int unsigned SEL_LSB     = 28,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_we,
   input  logic [31:0]             req_addr,
   input  logic [31:0]             req_wdata,
   input  logic [3:0]              req_be,
   output logic                    resp_valid,
   output logic [31:0]             resp_rdata,
   output logic                    resp_err,
   output logic [NUM_DEV-1:0]      dev_valid,
   output logic                    dev_we,
   output logic [31:0]             dev_addr,
   output logic [31:0]             dev_wdata,
   output logic [3:0]              dev_be,
   input  logic [NUM_DEV-1:0]      dev_ready,
   input  logic [NUM_DEV-1:0]      dev_rvalid,
   input  logic [32*NUM_DEV-1:0]   dev_rdata
);

   localparam int unsigned SEL_W = SEL_MSB - SEL_LSB + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_e;

   state_e               state_q;
   logic                 req_ready_q;
   logic                 resp_valid_q;
   logic                 resp_err_q;
   logic [31:0]          resp_rdata_q;
   logic [NUM_DEV-1:0]   dev_valid_q;
   logic [NUM_DEV-1:0]   sel_q;
   logic                 dev_we_q;
   logic [31:0]          dev_addr_q;
   logic [31:0]          dev_wdata_q;
   logic [3:0]           dev_be_q;

   logic [SEL_W-1:0]     req_sel;
   logic [NUM_DEV-1:0]   req_oh;
   logic                 sel_ready;
   logic                 sel_rvalid;
   logic [31:0]          sel_rdata;
   logic                 expire;

   // Address decode to one-hot (all-zero means no such slave) and selected-slave return mux.
   always_comb begin
      req_sel   = req_addr[SEL_MSB:SEL_LSB];
      req_oh    = '0;
      sel_rdata = '0;
      for (int unsigned i = 0; i < NUM_DEV; i++) begin
         if (32'(req_sel) == i) req_oh[i] = 1'b1;
         if (sel_q[i]) sel_rdata = sel_rdata | dev_rdata[32*i +: 32];
      end
      sel_ready  = |(dev_ready & sel_q);
      sel_rvalid = |(dev_rvalid & sel_q);
   end

`ifdef MMIO_TIMEOUT_EN
   localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

   logic [CNT_W-1:0] cnt_q;

   // ISSUE is only entered from IDLE, so holding zero in IDLE clears the count on entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (state_q == S_IDLE) begin
         cnt_q <= '0;
      end else if (state_q == S_ISSUE || state_q == S_WAIT) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign expire = (32'(cnt_q) + 32'd1) >= TIMEOUT_CYC;
`else
   logic unused_timeout;

   assign unused_timeout = ^32'(TIMEOUT_CYC);
   assign expire         = 1'b0;
`endif

   // Transaction FSM; every output comes straight from a register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
         dev_valid_q  <= '0;
         sel_q        <= '0;
         dev_we_q     <= 1'b0;
         dev_addr_q   <= '0;
         dev_wdata_q  <= '0;
         dev_be_q     <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  req_ready_q <= 1'b0;
                  dev_we_q    <= req_we;
                  dev_addr_q  <= req_addr;
                  dev_wdata_q <= req_wdata;
                  dev_be_q    <= req_be;
                  sel_q       <= req_oh;
                  if (req_oh == '0) begin
                     state_q      <= S_RESP;
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b1;
                     resp_rdata_q <= '0;
                  end else begin
                     state_q     <= S_ISSUE;
                     dev_valid_q <= req_oh;
                  end
               end
            end
            S_ISSUE: begin
               if (sel_ready) begin
                  dev_valid_q <= '0;
                  if (dev_we_q || sel_rvalid) begin
                     state_q      <= S_RESP;
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b0;
                     resp_rdata_q <= dev_we_q ? 32'd0 : sel_rdata;
                  end else begin
                     state_q <= S_WAIT;
                  end
               end else if (expire) begin
                  dev_valid_q  <= '0;
                  state_q      <= S_RESP;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= 1'b1;
                  resp_rdata_q <= '0;
               end
            end
            S_WAIT: begin
               if (sel_rvalid) begin
                  state_q      <= S_RESP;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= 1'b0;
                  resp_rdata_q <= sel_rdata;
               end else if (expire) begin
                  state_q      <= S_RESP;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= 1'b1;
                  resp_rdata_q <= '0;
               end
            end
            S_RESP: begin
               resp_valid_q <= 1'b0;
               req_ready_q  <= 1'b1;
               state_q      <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;
   assign dev_valid  = dev_valid_q;
   assign dev_we     = dev_we_q;
   assign dev_addr   = dev_addr_q;
   assign dev_wdata  = dev_wdata_q;
   assign dev_be     = dev_be_q;

endmodule

// File: tb/tb_mmio_demux.sv
// Self-checking bench for mmio_demux: vector table, corner sequences and random traffic vs a latency/data model.
module tb_mmio_demux;

   localparam int unsigned NUM_DEV = 4;
`ifdef MMIO_TIMEOUT_EN
   localparam int TO = 8;
`else
   localparam int TO = 255;
`endif

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  req_valid, req_ready, req_we;
   logic [31:0]           req_addr, req_wdata;
   logic [3:0]            req_be;
   logic                  resp_valid, resp_err;
   logic [31:0]           resp_rdata;
   logic [NUM_DEV-1:0]    dev_valid, dev_ready, dev_rvalid;
   logic                  dev_we;
   logic [31:0]           dev_addr, dev_wdata;
   logic [3:0]            dev_be;
   logic [32*NUM_DEV-1:0] dev_rdata;

   always #5 clk = ~clk;

   mmio_demux #(.NUM_DEV(NUM_DEV), .SEL_MSB(31), .SEL_LSB(28), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_be(req_be),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .dev_valid(dev_valid), .dev_we(dev_we), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
      .dev_be(dev_be), .dev_ready(dev_ready), .dev_rvalid(dev_rvalid), .dev_rdata(dev_rdata)
   );

   // rd: cycles dev_valid is up before the slave is ready; rvd: cycles from handshake to rvalid.
   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      int          rd;
      int          rvd;
      logic [31:0] rdata;
      logic        exp_err;
      logic [31:0] exp_rdata;
      int          exp_lat;
      int          exp_dv;
   } vec_t;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic we, input logic [31:0] a, input logic [31:0] wd,
                               input logic [3:0] be, input int rd, input int rvd,
                               input logic [31:0] rdt, input logic ee, input logic [31:0] ed,
                               input int el, input int edv);
      vec_t v;
      v.we = we; v.addr = a; v.wdata = wd; v.be = be; v.rd = rd; v.rvd = rvd; v.rdata = rdt;
      v.exp_err = ee; v.exp_rdata = ed; v.exp_lat = el; v.exp_dv = edv;
      return v;
   endfunction

   // Reference model: outcome and timing derived from the decode/latency/timeout rules.
   function automatic void model(inout vec_t v);
      int sel, comp;
      sel = int'(v.addr[31:28]);
      if (sel >= int'(NUM_DEV)) begin
         v.exp_err = 1'b1; v.exp_rdata = 32'd0; v.exp_lat = 1; v.exp_dv = 0;
         return;
      end
      comp = v.we ? (1 + v.rd) : (1 + v.rd + v.rvd);
      v.exp_err = 1'b0; v.exp_rdata = v.we ? 32'd0 : v.rdata;
      v.exp_lat = comp + 1; v.exp_dv = 1 + v.rd;
`ifdef MMIO_TIMEOUT_EN
      if (comp > TO) begin
         v.exp_err = 1'b1; v.exp_rdata = 32'd0; v.exp_lat = TO + 1;
         v.exp_dv = (1 + v.rd > TO) ? TO : 1 + v.rd;
      end
`endif
   endfunction

   task automatic run_txn(input vec_t v, input bit noise, input string tag);
      int sel, hs, lat, dv, w;
      bit oh_bad, fld_bad;
      logic err;
      logic [31:0] rdata;
      logic [NUM_DEV-1:0] exp_oh;
      sel    = int'(v.addr[31:28]);
      exp_oh = NUM_DEV'(1) << sel;
      hs = 1 + v.rd; lat = -1; dv = 0; oh_bad = 0; fld_bad = 0; err = 1'b0; rdata = '0;
      w = 0;
      while (!req_ready && w < 50) begin tick(); w++; end
      check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata; req_be = v.be;
      tick();
      req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_we = ~v.we;
      for (int c = 1; c <= 600 && lat < 0; c++) begin
         if (dev_valid != '0) begin
            dv++;
            if (dev_valid != exp_oh) oh_bad = 1;
            if (dev_addr != v.addr || dev_wdata != v.wdata || dev_we != v.we || dev_be != v.be)
               fld_bad = 1;
         end
         if (resp_valid) begin lat = c; err = resp_err; rdata = resp_rdata; end
         dev_ready  = noise ? NUM_DEV'($urandom) : '0;
         dev_rvalid = noise ? NUM_DEV'($urandom) : '0;
         for (int i = 0; i < int'(NUM_DEV); i++) dev_rdata[32*i +: 32] = $urandom;
         if (sel < int'(NUM_DEV)) begin
            dev_ready[sel]  = (c >= hs);
            dev_rvalid[sel] = !v.we && (c == hs + v.rvd);
            if (c == hs + v.rvd) dev_rdata[32*sel +: 32] = v.rdata;
         end
         tick();
      end
      dev_ready = '0; dev_rvalid = '0;
      check({tag, ".latency"}, 32'(lat), 32'(v.exp_lat));
      check({tag, ".err"}, 32'(err), 32'(v.exp_err));
      check({tag, ".rdata"}, rdata, v.exp_rdata);
      check({tag, ".dev_valid_cycles"}, 32'(dv), 32'(v.exp_dv));
      check({tag, ".dev_valid_onehot"}, 32'(oh_bad), 32'd0);
      check({tag, ".dev_fields"}, 32'(fld_bad), 32'd0);
      check({tag, ".resp_pulse_drop"}, 32'(resp_valid), 32'd0);
      check({tag, ".ready_after_resp"}, 32'(req_ready), 32'd1);
      check({tag, ".rdata_hold"}, resp_rdata, v.exp_rdata);
   endtask

   vec_t tbl[$];
   vec_t rv;
   bit   bad;

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
      dev_ready = '0; dev_rvalid = '0; dev_rdata = '0;
      tick(); tick();
      rst = 1'b0;
      tick();
      check("reset.req_ready", 32'(req_ready), 32'd1);
      check("reset.resp_valid", 32'(resp_valid), 32'd0);
      check("reset.resp", {resp_rdata[30:0], resp_err}, 32'd0);
      check("reset.dev_valid", 32'(dev_valid), 32'd0);
      check("reset.dev_bus", dev_addr | dev_wdata | 32'(dev_be) | 32'(dev_we), 32'd0);

      tbl.push_back(mk(1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 32'h0, 1'b0, 32'h0, 2, 1));
      tbl.push_back(mk(1'b0, 32'h2000_0000, 32'h0, 4'hF, 3, 2, 32'h1234_5678, 1'b0, 32'h1234_5678, 7, 4));
      tbl.push_back(mk(1'b0, 32'h7000_0000, 32'h0, 4'hF, 0, 0, 32'h0, 1'b1, 32'h0, 1, 0));
      tbl.push_back(mk(1'b0, 32'h0000_0004, 32'h0, 4'hF, 0, 0, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 2, 1));
      tbl.push_back(mk(1'b1, 32'h3000_0100, 32'h0BAD_C0DE, 4'h3, 2, 0, 32'h0, 1'b0, 32'h0, 4, 3));
      tbl.push_back(mk(1'b1, 32'hF000_0000, 32'h1111_2222, 4'h1, 0, 0, 32'h0, 1'b1, 32'h0, 1, 0));
      tbl.push_back(mk(1'b0, 32'h3000_0000, 32'h0, 4'hF, 1, 4, 32'hA5A5_5A5A, 1'b0, 32'hA5A5_5A5A, 7, 2));
      tbl.push_back(mk(1'b1, 32'h0000_0008, 32'h0000_00FF, 4'h8, 7, 0, 32'h0, 1'b0, 32'h0, 9, 8));
`ifdef MMIO_TIMEOUT_EN
      tbl.push_back(mk(1'b0, 32'h0000_0000, 32'h0, 4'hF, 20, 0, 32'h5555_5555, 1'b1, 32'h0, 9, 8));
      tbl.push_back(mk(1'b0, 32'h1000_0000, 32'h0, 4'hF, 2, 6, 32'h6666_6666, 1'b1, 32'h0, 9, 3));
`else
      tbl.push_back(mk(1'b0, 32'h0000_0000, 32'h0, 4'hF, 300, 0, 32'h5555_5555, 1'b0, 32'h5555_5555, 302, 301));
`endif
      foreach (tbl[i]) run_txn(tbl[i], (i % 2) == 1, $sformatf("vec%0d", i));

      // Stray rvalid from slave 3 while a read to slave 0 waits.
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0000; req_be = 4'hF;
      tick();
      req_valid = 1'b0; dev_ready = 4'b0001;
      tick();
      dev_ready = 4'b1000; dev_rvalid = 4'b1000; dev_rdata = '0; dev_rdata[127:96] = 32'hFFFF_FFFF;
      tick();
      check("stray.no_resp", 32'(resp_valid), 32'd0);
      dev_ready = '0; dev_rvalid = 4'b0001; dev_rdata[31:0] = 32'h0000_00AA;
      tick();
      dev_rvalid = '0;
      check("stray.resp_valid", 32'(resp_valid), 32'd1);
      check("stray.rdata", resp_rdata, 32'h0000_00AA);
      check("stray.err", 32'(resp_err), 32'd0);
      tick();

      // Reset while a read to slave 1 sits in WAIT; its late rvalid must be ignored.
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h1000_0000;
      tick();
      req_valid = 1'b0; dev_ready = 4'b0010;
      tick();
      dev_ready = '0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0; dev_rvalid = 4'b0010; dev_rdata[63:32] = 32'h7777_7777;
      bad = 0;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (resp_valid) bad = 1;
      end
      dev_rvalid = '0;
      check("rst_wait.no_resp", 32'(bad), 32'd0);
      check("rst_wait.dev_valid", 32'(dev_valid), 32'd0);
      check("rst_wait.req_ready", 32'(req_ready), 32'd1);

      for (int n = 0; n < 40; n++) begin
         rv.we    = 1'($urandom);
         rv.addr  = {4'($urandom_range(0, 5)), 28'($urandom)};
         rv.wdata = $urandom;
         rv.be    = 4'($urandom);
         rv.rd    = int'($urandom_range(0, 5));
         rv.rvd   = int'($urandom_range(0, 5));
         rv.rdata = $urandom;
         model(rv);
         run_txn(rv, 1'b1, $sformatf("rnd%0d", n));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mmio_demux.md
Name: mmio_demux

Overview:
- One-to-many router between the core's single load/store port and NUM_DEV memory-mapped slaves (data RAM, timer, GPIO, UART).
- Decodes the request address, forwards the request to exactly one slave with a valid/ready handshake, and collects that slave's read data.
- Returns one response (data or error) to the core.
- Sits between the core's data-memory port and the peripheral slaves.

Parameters:
- NUM_DEV, 4, number of slave ports (1..16).
- SEL_MSB, 31, MSB of the address slave-select field.
- SEL_LSB, 28, LSB of the address slave-select field (field width = SEL_MSB-SEL_LSB+1).
- TIMEOUT_CYC, 255, cycles spent in ISSUE+WAIT before a timeout error (used only with the optional feature).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  router idle, request accepted this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_be  in  4  byte enables.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  load data; 0 on writes or errors.
- resp_err  out  1  decode or timeout error.
- dev_valid  out  NUM_DEV  one-hot request to the selected slave.
- dev_we  out  1  shared, latched copy of req_we.
- dev_addr  out  32  shared, latched copy of req_addr.
- dev_wdata  out  32  shared, latched copy of req_wdata.
- dev_be  out  4  shared, latched copy of req_be.
- dev_ready  in  NUM_DEV  per-slave request accept.
- dev_rvalid  in  NUM_DEV  per-slave read-data valid.
- dev_rdata  in  32*NUM_DEV  per-slave read data; slave i occupies bits [32i+31:32i].

Behaviour:
- Reset (synchronous): state=IDLE; req_ready=1 after reset; resp_valid=0, resp_rdata=0, resp_err=0, dev_valid=0, dev_we=0, dev_addr=0, dev_wdata=0, dev_be=0; counter=0. A reset mid-transaction abandons it and issues no response. dev_* inputs arriving after reset are ignored.
- State machine: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch we/addr/wdata/be into the dev_* registers and idx=addr[SEL_MSB:SEL_LSB].
  - idx>=NUM_DEV: go to RESP with err=1, rdata=0.
  - Otherwise go to ISSUE.
- ISSUE:
  - dev_valid[idx]=1; all other dev_valid bits 0; req_ready=0.
  - Hold until dev_ready[idx]=1.
  - Write: go to RESP with err=0.
  - Read with dev_rvalid[idx]=1 in the same cycle: capture rdata slice and go to RESP.
  - Read otherwise: go to WAIT.
  - dev_valid drops in the cycle after the handshake.
- WAIT:
  - dev_valid=0.
  - On dev_rvalid[idx], capture dev_rdata slice idx and go to RESP.
  - dev_ready/dev_rvalid from non-selected slaves are ignored in every state.
- RESP:
  - resp_valid=1 for exactly one cycle with the registered rdata/err, then IDLE.
  - No response backpressure.
  - resp_rdata/resp_err hold their values until the next response.
- Latency (request accepted at cycle 0):
  - Decode error: resp_valid at cycle 1.
  - Write with immediate dev_ready: dev_valid at 1, resp_valid at 2.
  - Read with ready and rvalid both at cycle 1: resp_valid at 2.
  - Each extra slave wait cycle adds 1.
- Throughput: at most one outstanding transaction. req_valid asserted during ISSUE/WAIT/RESP is not accepted (req_ready=0).

Optional Feature:
- Macro: MMIO_TIMEOUT_EN.
- Defined:
  - An 8+-bit counter clears on entry to ISSUE and increments each cycle in ISSUE or WAIT.
  - When the count reaches TIMEOUT_CYC with no completion, dev_valid drops, the next state is RESP with err=1 and rdata=0, and any later dev_rvalid for that transaction is ignored.
  - Completion in the same cycle as the count reaching TIMEOUT_CYC counts as success.
- Undefined: no counter; ISSUE and WAIT wait indefinitely.

Test Plan:
- Reset during WAIT (read to slave 1 pending), then dev_rvalid[1]=1 after reset -> no resp_valid; dev_valid=0; req_ready=1.
- Store addr=0x1000_0010, wdata=0xDEADBEEF, be=0xF, dev_ready[1] held high -> dev_valid=4'b0010 at cycle 1 with dev_addr=0x1000_0010 and dev_wdata=0xDEADBEEF; resp_valid at cycle 2, err=0, rdata=0.
- Load addr=0x2000_0000, slave 2 raises ready after 3 cycles and rvalid 2 cycles later with rdata=0x12345678 -> single resp_valid with rdata=0x12345678, err=0; dev_valid[2] high for exactly 4 cycles.
- Load addr=0x7000_0000 (NUM_DEV=4) -> resp_valid at cycle 1, err=1, rdata=0; dev_valid stays 0.
- During a pending read to slave 0, pulse dev_rvalid[3] with 0xFFFF_FFFF, then dev_rvalid[0] with 0x0000_00AA -> resp_rdata=0x0000_00AA.
- MMIO_TIMEOUT_EN defined, TIMEOUT_CYC=8, dev_ready[0] held low -> resp_valid with err=1 exactly 8 cycles after ISSUE entry; dev_valid drops at the same time; req_ready returns to 1 the following cycle.
